mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares one single-port memory bus between instruction fetch (IF) and the MEM stage.
//   Sequences each access with a cycle/strobe/ack handshake.
//   Returns read data to the requester and raises pipeline stall requests while an access is outstanding.
//   A timeout aborts accesses to a slave that never answers.
//   Sits between the IF/MEM stages and the external memory/bus interface.
// PARAMETERS
//   ADDR_W       32  bus address width
//   DATA_W       32  bus data width (SEL_W = DATA_W/8)
//   TIMEOUT_CYC  16  max cycles in a BUSY state waiting for bus_ack_i; legal range 2..255
// PORTS
//   clk             in   1       clock, rising edge
//   rst             in   1       asynchronous reset, active-high
//   if_req_i        in   1       IF read request (level)
//   if_addr_i       in   ADDR_W  IF fetch address
//   if_rdata_o      out  DATA_W  fetched word, valid while if_ack_o=1
//   if_ack_o        out  1       IF access complete (1-cycle pulse)
//   mem_req_i       in   1       MEM access request (level)
//   mem_we_i        in   1       1=store, 0=load
//   mem_sel_i       in   SEL_W   byte enables
//   mem_addr_i      in   ADDR_W  data address
//   mem_wdata_i     in   DATA_W  store data
//   mem_rdata_o     out  DATA_W  load data, valid while mem_ack_o=1
//   mem_ack_o       out  1       MEM access complete (1-cycle pulse)
//   bus_cyc_o       out  1       bus cycle active
//   bus_stb_o       out  1       bus strobe
//   bus_we_o        out  1       bus write enable
//   bus_sel_o       out  SEL_W   bus byte enables
//   bus_addr_o      out  ADDR_W  bus address
//   bus_wdata_o     out  DATA_W  bus write data
//   bus_rdata_i     in   DATA_W  bus read data, sampled with bus_ack_i
//   bus_ack_i       in   1       slave acknowledge
//   stallreq_if_o   out  1       IF stall request
//   stallreq_mem_o  out  1       MEM stall request
//   bus_err_o       out  1       timeout abort (1-cycle pulse)
// BEHAVIOUR
//   - Reset is asynchronous and active-high.
//     - rst=1: state IDLE, timeout counter 0.
//     - All registered outputs 0; bus_cyc_o/bus_stb_o drop immediately.
//     - Reset mid-access abandons the access with no ack.
//   - FSM states: IDLE, IF_BUSY, MEM_BUSY, DONE. Arbitration happens only in IDLE.
//   - IDLE, arbitration (MEM has fixed priority; this is safe because IF stalls whenever MEM stalls):
//     - mem_req_i=1: latch mem_we/sel/addr/wdata into bus regs, go to MEM_BUSY.
//     - else if_req_i=1: latch addr with we=0, sel=all ones, go to IF_BUSY.
//     - else stay in IDLE.
//   - BUSY states:
//     - bus_cyc_o = bus_stb_o = 1; bus regs held stable; counter increments each cycle.
//     - bus_ack_i=1: capture bus_rdata_i into the owner's rdata_o, go to DONE.
//     - counter reaches TIMEOUT_CYC-1 without ack: rdata_o <= 0, bus_err_o <= 1, go to DONE.
//   - DONE (exactly 1 cycle):
//     - The owner's ack_o=1; cyc/stb=0; counter cleared; return to IDLE unconditionally.
//     - rdata_o holds its value until the next capture.
//     - Store acks return rdata_o=0.
//   - Requester contract: hold req and all request fields stable until it sees ack_o high at a clock edge.
//     - At that edge it drops req or presents a new request.
//     - Once in DONE, a req still high is treated as new only from IDLE, one cycle later.
//   - Latency: req sampled at edge 0 -> cyc/stb from cycle 1; zero-wait slave ack in cycle 1 -> ack_o in cycle 2.
//     - One idle turnaround cycle separates back-to-back grants.
//   - Stalls (combinational):
//     - stallreq_mem_o = mem_req_i & ~mem_ack_o.
//     - stallreq_if_o = if_req_i & ~if_ack_o.
//   - Simultaneous IF and MEM requests: MEM is served first; IF waits in IDLE arbitration.
//   - bus_ack_i outside BUSY states is ignored.
//   - An ack in the same cycle the counter expires counts as success, with no error.
// TESTING
//   - Reset: assert rst mid-MEM_BUSY -> cyc/stb/ack/err=0 same cycle; IDLE after release, no ack issued.
//   - Single IF read: if_addr=0x00400000, slave acks cycle 1 with 0x8C220004.
//     - if_ack_o=1 cycle 2 with if_rdata_o=0x8C220004.
//     - bus_sel_o=4'hF, bus_we_o=0.
//   - Contention: if_req and mem_req (store, addr 0x10010000, sel 4'h3, wdata 0xDEADBEEF) in the same cycle.
//     - MEM granted first; bus_we_o=1, bus_sel_o=4'h3, mem_ack_o pulse.
//     - IF granted after a 1-cycle turnaround.
//     - stallreq_if_o stays 1 throughout.
//   - Wait states: slave delays ack 5 cycles on a load returning 0x12345678.
//     - Bus fields stable; stallreq_mem_o=1 until mem_ack_o; mem_rdata_o=0x12345678.
//   - Timeout: TIMEOUT_CYC=16 with no ack.
//     - DONE after 16 BUSY cycles; bus_err_o and mem_ack_o pulse together; mem_rdata_o=0.
//     - Next request proceeds normally.
//   - Edge: ack on the final timeout cycle -> success, bus_err_o=0, data captured.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the MEM stage.
// MEM wins arbitration; each access completes by slave ack or timeout.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  localparam int SEL_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [SEL_W-1:0]  mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o,
  output logic              bus_err_o
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DONE} state_t;

  state_t            state, next_state;
  logic [7:0]        cnt;
  logic              owner_mem;
  logic              busy;
  logic              grant_mem, grant_if, timed_out;
  logic              bus_we;
  logic [SEL_W-1:0]  bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] if_rdata, mem_rdata;
  logic              bus_err;

  assign busy = (state == IF_BUSY) || (state == MEM_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant_mem  = 1'b0;
    grant_if   = 1'b0;
    timed_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_req_i) begin
          grant_mem  = 1'b1;
          next_state = MEM_BUSY;
        end else if (if_req_i) begin
          grant_if   = 1'b1;
          next_state = IF_BUSY;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (bus_ack_i) begin
          next_state = DONE;
        end else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
          timed_out  = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      owner_mem <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (grant_mem) begin
        owner_mem <= 1'b1;
        bus_we    <= mem_we_i;
        bus_sel   <= mem_sel_i;
        bus_addr  <= mem_addr_i;
        bus_wdata <= mem_wdata_i;
      end else if (grant_if) begin
        owner_mem <= 1'b0;
        bus_we    <= 1'b0;
        bus_sel   <= '1;
        bus_addr  <= if_addr_i;
        bus_wdata <= '0;
      end

      if (busy && next_state != DONE) cnt <= cnt + 8'd1;
      else                            cnt <= '0;

      // Stores and timeouts hand back zero rather than whatever is on the bus.
      if (busy && bus_ack_i) begin
        if (state == MEM_BUSY) mem_rdata <= bus_we ? '0 : bus_rdata_i;
        else                   if_rdata  <= bus_rdata_i;
      end else if (timed_out) begin
        if (state == MEM_BUSY) mem_rdata <= '0;
        else                   if_rdata  <= '0;
      end

      bus_err <= timed_out;
    end
  end

  assign bus_cyc_o      = busy;
  assign bus_stb_o      = busy;
  assign bus_we_o       = bus_we;
  assign bus_sel_o      = bus_sel;
  assign bus_addr_o     = bus_addr;
  assign bus_wdata_o    = bus_wdata;
  assign bus_err_o      = bus_err;
  assign if_rdata_o     = if_rdata;
  assign mem_rdata_o    = mem_rdata;
  assign if_ack_o       = (state == DONE) && !owner_mem;
  assign mem_ack_o      = (state == DONE) && owner_mem;
  assign stallreq_if_o  = if_req_i & ~if_ack_o;
  assign stallreq_mem_o = mem_req_i & ~mem_ack_o;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized transactions checked against a transaction-level outcome model.
module tb_mem_bus_arbiter;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int SEL_W       = 4;
  localparam int TIMEOUT_CYC = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;
  logic              mem_req_i = 1'b0;
  logic              mem_we_i = 1'b0;
  logic [SEL_W-1:0]  mem_sel_i = '0;
  logic [ADDR_W-1:0] mem_addr_i = '0;
  logic [DATA_W-1:0] mem_wdata_i = '0;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_ack_o;
  logic              bus_cyc_o;
  logic              bus_stb_o;
  logic              bus_we_o;
  logic [SEL_W-1:0]  bus_sel_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i = '0;
  logic              bus_ack_i = 1'b0;
  logic              stallreq_if_o;
  logic              stallreq_mem_o;
  logic              bus_err_o;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic mreq, input logic mwe, input logic [3:0] msel,
                               input logic [31:0] maddr, input logic [31:0] mwdata,
                               input logic ireq, input logic [31:0] iaddr);
    mem_req_i   = mreq;
    mem_we_i    = mwe;
    mem_sel_i   = msel;
    mem_addr_i  = maddr;
    mem_wdata_i = mwdata;
    if_req_i    = ireq;
    if_addr_i   = iaddr;
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 1000;
    if (r == 1) return TIMEOUT_CYC - 1;
    return int'($urandom_range(0, 6));
  endfunction

  // Runs one granted access with a slave that acks after ack_delay busy cycles
  // (never, if ack_delay >= TIMEOUT_CYC), then checks the predicted outcome.
  task automatic doTransaction(input string tag, input bit exp_mem, input int ack_delay,
                               input logic [31:0] slave_data, input int exp_pre);
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_addr, exp_wdata, exp_rdata, got_rdata;
    bit          exp_err, done, stable;
    int          exp_busy, pre, busy;
    exp_we    = exp_mem ? mem_we_i : 1'b0;
    exp_sel   = exp_mem ? mem_sel_i : 4'hF;
    exp_addr  = exp_mem ? mem_addr_i : if_addr_i;
    exp_wdata = mem_wdata_i;
    exp_err   = (ack_delay >= TIMEOUT_CYC);
    exp_busy  = exp_err ? TIMEOUT_CYC : ack_delay + 1;
    exp_rdata = (exp_err || exp_we) ? 32'h0 : slave_data;
    done = 1'b0; stable = 1'b1; pre = 0; busy = 0;
    for (int c = 0; c < TIMEOUT_CYC + 6 && !done; c++) begin
      tick();
      if (mem_ack_o || if_ack_o) begin
        done = 1'b1;
      end else if (bus_cyc_o) begin
        if (bus_stb_o !== 1'b1 || bus_we_o !== exp_we || bus_sel_o !== exp_sel ||
            bus_addr_o !== exp_addr || (exp_mem && bus_wdata_o !== exp_wdata) ||
            stallreq_mem_o !== mem_req_i || stallreq_if_o !== if_req_i || bus_err_o !== 1'b0)
          stable = 1'b0;
        bus_ack_i   = (busy == ack_delay);
        bus_rdata_i = (busy == ack_delay) ? slave_data : $urandom();
        busy++;
      end else begin
        if (busy == 0) pre++;
        else stable = 1'b0;
      end
    end
    bus_ack_i = 1'b0;
    got_rdata = exp_mem ? mem_rdata_o : if_rdata_o;
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " wait_before_grant"}, 32'(pre), 32'(exp_pre));
    checkOutput({tag, " busy_cycles"}, 32'(busy), 32'(exp_busy));
    checkOutput({tag, " bus_fields_stable"}, 32'(stable), 32'd1);
    checkOutput({tag, " mem_ack"}, 32'(mem_ack_o), 32'(exp_mem));
    checkOutput({tag, " if_ack"}, 32'(if_ack_o), 32'(!exp_mem));
    checkOutput({tag, " rdata"}, got_rdata, exp_rdata);
    checkOutput({tag, " bus_err"}, 32'(bus_err_o), 32'(exp_err));
    checkOutput({tag, " cyc_in_done"}, 32'(bus_cyc_o), 32'd0);
    checkOutput({tag, " owner_stall"}, 32'(exp_mem ? stallreq_mem_o : stallreq_if_o), 32'd0);
  endtask

  initial begin
    logic mreq, ireq;

    tick();
    tick();
    checkOutput("reset cyc", 32'(bus_cyc_o), 32'd0);
    checkOutput("reset stb", 32'(bus_stb_o), 32'd0);
    checkOutput("reset acks", 32'({mem_ack_o, if_ack_o}), 32'd0);
    checkOutput("reset err", 32'(bus_err_o), 32'd0);
    checkOutput("reset sel", 32'(bus_sel_o), 32'd0);
    checkOutput("reset mem_rdata", mem_rdata_o, 32'd0);
    rst = 1'b0;
    tick();

    bus_ack_i = 1'b1;
    tick();
    tick();
    checkOutput("stray_ack acks", 32'({mem_ack_o, if_ack_o}), 32'd0);
    checkOutput("stray_ack cyc", 32'(bus_cyc_o), 32'd0);
    bus_ack_i = 1'b0;

    applyStimulus(1'b1, 1'b0, 4'hF, 32'h2000_0000, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("midreset busy_before", 32'(bus_cyc_o), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midreset cyc", 32'(bus_cyc_o), 32'd0);
    checkOutput("midreset stb", 32'(bus_stb_o), 32'd0);
    checkOutput("midreset ack", 32'(mem_ack_o), 32'd0);
    checkOutput("midreset err", 32'(bus_err_o), 32'd0);
    mem_req_i = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("postreset no_ack", 32'({mem_ack_o, if_ack_o, bus_cyc_o}), 32'd0);
    end

    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0040_0000);
    doTransaction("if_read", 1'b0, 0, 32'h8C22_0004, 0);
    if_req_i = 1'b0;
    tick();

    applyStimulus(1'b1, 1'b1, 4'h3, 32'h1001_0000, 32'hDEAD_BEEF, 1'b1, 32'h0040_0004);
    #1;
    checkOutput("contend stall_if", 32'(stallreq_if_o), 32'd1);
    checkOutput("contend stall_mem", 32'(stallreq_mem_o), 32'd1);
    doTransaction("contend_mem", 1'b1, 0, $urandom(), 0);
    mem_req_i = 1'b0;
    #1;
    checkOutput("contend stall_if_at_mem_ack", 32'(stallreq_if_o), 32'd1);
    doTransaction("contend_if", 1'b0, 1, 32'hA5A5_0001, 1);
    if_req_i = 1'b0;
    tick();

    applyStimulus(1'b1, 1'b0, 4'hF, 32'h1001_0040, 32'h0, 1'b0, 32'h0);
    doTransaction("wait_load", 1'b1, 5, 32'h1234_5678, 0);
    mem_req_i = 1'b0;
    tick();

    applyStimulus(1'b1, 1'b0, 4'hF, 32'h3000_0000, 32'h0, 1'b0, 32'h0);
    doTransaction("timeout", 1'b1, 1000, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 4'hC, 32'h1001_0080, 32'h0, 1'b0, 32'h0);
    doTransaction("after_timeout", 1'b1, 2, 32'hCAFE_F00D, 1);
    mem_req_i = 1'b0;
    tick();

    applyStimulus(1'b1, 1'b0, 4'hF, 32'h1001_00C0, 32'h0, 1'b0, 32'h0);
    doTransaction("edge_ack", 1'b1, TIMEOUT_CYC - 1, 32'h0BAD_C0DE, 0);
    mem_req_i = 1'b0;
    tick();

    for (int n = 0; n < 20; n++) begin
      mreq = 1'($urandom_range(0, 1));
      ireq = 1'($urandom_range(0, 1));
      if (!mreq && !ireq) ireq = 1'b1;
      applyStimulus(mreq, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                    $urandom(), $urandom(), ireq, $urandom());
      doTransaction("rnd_first", mreq, pick_delay(), $urandom(), 0);
      if (mreq && ireq) begin
        mem_req_i = 1'b0;
        doTransaction("rnd_second", 1'b0, pick_delay(), $urandom(), 1);
      end
      mem_req_i = 1'b0;
      if_req_i  = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
